// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   DEF_REG_W        default register-index width
//   DEF_CNT_W        default stall performance-counter width
//   DEF_MEM_TIMEOUT  default max consecutive stalled data-memory cycles
//   ctrl_state_e     sequencer states (RUN, MEM_WAIT, ERR)
package pipe_ctrl_pkg;

    localparam int DEF_REG_W       = 5;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MEM_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the datapath and the hazard sequencer.
//   master : datapath side, drives ID/EX/MEM status, receives stage enables
//   slave  : sequencer side, samples status, drives enables/valids/flush,
//            timeout flag and stall counter
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_uses_rs_i;
    logic             id_uses_rt_i;
    logic [REG_W-1:0] ex_rsd_i;
    logic             ex_is_load_i;
    logic             ex_valid_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             mem_ready_i;

    logic             pc_en_o;
    logic             if_id_en_o;
    logic             if_id_flush_o;
    logic             id_ex_en_o;
    logic             id_ex_valid_o;
    logic             ex_mem_en_o;
    logic             mem_wb_valid_o;
    logic             timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
               ex_rsd_i, ex_is_load_i, ex_valid_i,
               branch_taken_i, mem_req_i, mem_ready_i,
        input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_valid_o,
               ex_mem_en_o, mem_wb_valid_o, timeout_o, stall_cnt_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
               ex_rsd_i, ex_is_load_i, ex_valid_i,
               branch_taken_i, mem_req_i, mem_ready_i,
        output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_valid_o,
               ex_mem_en_o, mem_wb_valid_o, timeout_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare (purely combinational).
//   id_rs_i/id_rt_i        source registers of the ID instruction
//   id_uses_rs_i/_rt_i     which sources the ID instruction actually reads
//   ex_rsd_i               destination of the EX instruction
//   ex_is_load_i           EX instruction is a load
//   ex_valid_i             EX holds a real instruction
//   load_use_o             ID needs a load result not yet available
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic [REG_W-1:0] ex_rsd_i,
    input  logic             ex_is_load_i,
    input  logic             ex_valid_i,
    output logic             load_use_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs_i && (id_rs_i == ex_rsd_i);
    assign rt_match = id_uses_rt_i && (id_rt_i == ex_rsd_i);

    // Register 0 is hard-wired zero, so a load targeting it never stalls.
    assign load_use_o = ex_valid_i && ex_is_load_i && (ex_rsd_i != '0)
                        && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   clk_i  clock
//   rst_i  asynchronous active-low reset (bubbles the whole pipe while low)
//   bus    slave side of pipe_hazard_ctrl_if: hazard inputs in, PC/buffer
//          enables, valids, IF/ID flush, sticky timeout and stall counter out
// Outputs are combinational from state and current inputs so the pipeline
// buffers act on them at the same clock edge.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = DEF_REG_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic load_use;
    logic mem_stall;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_valid;
    logic ex_mem_en, mem_wb_valid, timeout;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .id_rs_i      (bus.id_rs_i),
        .id_rt_i      (bus.id_rt_i),
        .id_uses_rs_i (bus.id_uses_rs_i),
        .id_uses_rt_i (bus.id_uses_rt_i),
        .ex_rsd_i     (bus.ex_rsd_i),
        .ex_is_load_i (bus.ex_is_load_i),
        .ex_valid_i   (bus.ex_valid_i),
        .load_use_o   (load_use)
    );

    assign mem_stall = bus.mem_req_i && !bus.mem_ready_i;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_valid  = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_valid = 1'b1;
        timeout      = (state_q == ST_ERR);

        // Stage control; branch is ignored under any stall since its
        // operands are not yet valid and ID will re-assert it.
        if (state_q == ST_ERR || mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_valid = 1'b0;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_valid = 1'b0;
        end else if (bus.branch_taken_i) begin
            if_id_flush = 1'b1;
        end

        // wait_cnt counts consecutive stalled cycles including the one in RUN.
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    if (MEM_TIMEOUT <= 1) begin
                        state_d    = ST_ERR;
                        wait_cnt_d = '0;
                    end else begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q >= WAIT_LAST) begin
                    state_d    = ST_ERR;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                state_d    = ST_ERR;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (!rst_i) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b0;
            id_ex_valid  = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_valid = 1'b0;
            timeout      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (!pc_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.pc_en_o        = pc_en;
    assign bus.if_id_en_o     = if_id_en;
    assign bus.if_id_flush_o  = if_id_flush;
    assign bus.id_ex_en_o     = id_ex_en;
    assign bus.id_ex_valid_o  = id_ex_valid;
    assign bus.ex_mem_en_o    = ex_mem_en;
    assign bus.mem_wb_valid_o = mem_wb_valid;
    assign bus.timeout_o      = timeout;
    assign bus.stall_cnt_o    = stall_cnt_q;

endmodule
